// File: rtl/bp_me_wormhole_flit_assembler.sv
// Receive-side wormhole flit assembler: collects header-on-LSB flits into one packet
// buffer, strips x/y/len and presents the payload on a valid/ready interface.
module bp_me_wormhole_flit_assembler #(
  parameter int max_num_flit_p   = 4,
  parameter int x_cord_width_p   = 4,
  parameter int y_cord_width_p   = 4,
  parameter int payload_width_p  = 118,
  localparam int len_width_lp    = $clog2(max_num_flit_p),
  localparam int packet_width_lp = x_cord_width_p + y_cord_width_p + len_width_lp + payload_width_p,
  localparam int flit_width_lp   = (packet_width_lp + max_num_flit_p - 1) / max_num_flit_p
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  input  logic [flit_width_lp-1:0]   flit_i,
  input  logic                       flit_v_i,
  output logic                       flit_ready_o,
  output logic [payload_width_p-1:0] payload_o,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic                       misroute_o,
  output logic                       len_err_o
);

  localparam int payload_offset_lp = x_cord_width_p + y_cord_width_p + len_width_lp;
  localparam int buf_width_lp      = max_num_flit_p * flit_width_lp;
  localparam logic [len_width_lp:0] len_max_lp = (len_width_lp + 1)'(max_num_flit_p - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FULL} state_e;

  state_e                    r_state;
  logic [len_width_lp-1:0]   r_cnt;
  logic [len_width_lp-1:0]   r_len;
  logic                      r_misroute;
  logic                      r_len_err;
  logic [flit_width_lp-1:0]  r_slot [max_num_flit_p];

  logic                      w_xfer;
  logic                      w_hdr_xfer;
  logic                      w_body_xfer;
  logic [x_cord_width_p-1:0] w_hdr_x;
  logic [y_cord_width_p-1:0] w_hdr_y;
  logic [len_width_lp-1:0]   w_hdr_len;
  logic [len_width_lp:0]     w_len_diff;
  logic                      w_hdr_len_err;
  logic [len_width_lp-1:0]   w_len_eff;
  logic [buf_width_lp-1:0]   w_buf;
  logic                      w_unused_hdr_bits;

  assign w_hdr_x   = flit_i[0 +: x_cord_width_p];
  assign w_hdr_y   = flit_i[x_cord_width_p +: y_cord_width_p];
  assign w_hdr_len = flit_i[x_cord_width_p + y_cord_width_p +: len_width_lp];

  // Borrow out of (max-1) - len flags an oversize length without a constant-range compare.
  assign w_len_diff    = len_max_lp - {1'b0, w_hdr_len};
  assign w_hdr_len_err = w_len_diff[len_width_lp];
  assign w_len_eff     = w_hdr_len_err ? len_max_lp[len_width_lp-1:0] : w_hdr_len;

  // In FULL, the router side may only move when the consumer drains this cycle.
  assign flit_ready_o = reset_n_i & ((r_state == S_FULL) ? ready_i : 1'b1);
  assign w_xfer       = flit_v_i & flit_ready_o;
  assign w_hdr_xfer   = w_xfer & (r_state != S_COLLECT);
  assign w_body_xfer  = w_xfer & (r_state == S_COLLECT);

  assign v_o        = (r_state == S_FULL);
  assign misroute_o = r_misroute;
  assign len_err_o  = r_len_err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_misroute <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_hdr_xfer) begin
        r_cnt   <= len_width_lp'(1);
        r_len   <= w_len_eff;
        r_state <= (w_len_eff == '0) ? S_FULL : S_COLLECT;
        if ((w_hdr_x != my_x_i) || (w_hdr_y != my_y_i))
          r_misroute <= 1'b1;
        if (w_hdr_len_err)
          r_len_err <= 1'b1;
      end else begin
        case (r_state)
          S_COLLECT: begin
            if (w_body_xfer) begin
              if (r_cnt == r_len)
                r_state <= S_FULL;
              else
                r_cnt <= r_cnt + 1'b1;
            end
          end
          S_FULL: begin
            if (ready_i)
              r_state <= S_IDLE;
          end
          S_IDLE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // A header wipes every slot, so slots past len read back as zero.
  for (genvar gi = 0; gi < max_num_flit_p; gi++) begin : g_slot
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_slot[gi] <= '0;
      end else if (w_hdr_xfer) begin
        r_slot[gi] <= (gi == 0) ? flit_i : '0;
      end else if (w_body_xfer && (r_cnt == len_width_lp'(gi))) begin
        r_slot[gi] <= flit_i;
      end
    end
    assign w_buf[gi*flit_width_lp +: flit_width_lp] = r_slot[gi];
  end

  assign payload_o = w_buf[payload_offset_lp +: payload_width_p];

  assign w_unused_hdr_bits = &{1'b0, w_buf[payload_offset_lp-1:0]};

endmodule

// File: tb/tb_bp_me_wormhole_flit_assembler.sv
// Directed bench for the wormhole flit assembler: packet reassembly, backpressure,
// bubbles, misroute flag and mid-packet reset.
module tb_bp_me_wormhole_flit_assembler;

  logic         clk_i;
  logic         reset_n_i;
  logic [3:0]   my_x_i;
  logic [3:0]   my_y_i;
  logic [31:0]  flit_i;
  logic         flit_v_i;
  logic         flit_ready_o;
  logic [117:0] payload_o;
  logic         v_o;
  logic         ready_i;
  logic         misroute_o;
  logic         len_err_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bp_me_wormhole_flit_assembler dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .my_x_i       (my_x_i),
    .my_y_i       (my_y_i),
    .flit_i       (flit_i),
    .flit_v_i     (flit_v_i),
    .flit_ready_o (flit_ready_o),
    .payload_o    (payload_o),
    .v_o          (v_o),
    .ready_i      (ready_i),
    .misroute_o   (misroute_o),
    .len_err_o    (len_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam logic [117:0] P_BIG  = 118'h2A_DEAD_BEEF_CAFE_F00D_1234_5678_A5;
  localparam logic [117:0] P_MIS  = 118'h0012_3456_789A_BCDE;
  localparam logic [117:0] P_HDR  = 118'h2ABCDE;

  function automatic logic [127:0] mk_pkt(input logic [3:0] x, input logic [3:0] y,
                                          input logic [1:0] len, input logic [117:0] pl);
    return {pl, len, y, x};
  endfunction

  // Drives flits first..last of pkt, one per cycle, with gap idle cycles between them.
  task automatic send_range(input logic [127:0] pkt, input int first, input int last, input int gap);
    for (int k = first; k <= last; k++) begin
      flit_i   = pkt[k*32 +: 32];
      flit_v_i = 1'b1;
      @(posedge clk_i); #1;
      flit_v_i = 1'b0;
      if (k != last) repeat (gap) begin @(posedge clk_i); #1; end
    end
  endtask

  task automatic drain();
    flit_v_i = 1'b0;
    ready_i  = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; flit_v_i = 1'b0; flit_i = '0; ready_i = 1'b1;
    my_x_i = 4'd2; my_y_i = 4'd3;
    repeat (2) @(posedge clk_i); #1;
    total_cnt++; if (v_o !== 1'b0) $display("FAIL reset_v got=%0b exp=0", v_o); else pass_cnt++;
    total_cnt++; if (flit_ready_o !== 1'b0) $display("FAIL reset_rdy got=%0b exp=0", flit_ready_o); else pass_cnt++;
    total_cnt++; if (misroute_o !== 1'b0) $display("FAIL reset_mis got=%0b exp=0", misroute_o); else pass_cnt++;
    total_cnt++; if (len_err_o !== 1'b0) $display("FAIL reset_lenerr got=%0b exp=0", len_err_o); else pass_cnt++;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    total_cnt++; if (flit_ready_o !== 1'b1) $display("FAIL idle_rdy got=%0b exp=1", flit_ready_o); else pass_cnt++;
    $display("reset: v=%0b rdy=%0b", v_o, flit_ready_o);
  endtask

  task automatic test_four_flit();
    logic [127:0] pkt;
    pkt = mk_pkt(4'd2, 4'd3, 2'd3, P_BIG);
    ready_i = 1'b1;
    send_range(pkt, 0, 2, 0);
    total_cnt++; if (v_o !== 1'b0) $display("FAIL four_v_early got=%0b exp=0", v_o); else pass_cnt++;
    send_range(pkt, 3, 3, 0);
    total_cnt++; if (v_o !== 1'b1) $display("FAIL four_v got=%0b exp=1", v_o); else pass_cnt++;
    total_cnt++; if (payload_o !== P_BIG) $display("FAIL four_payload got=%h exp=%h", payload_o, P_BIG); else pass_cnt++;
    total_cnt++; if (misroute_o !== 1'b0) $display("FAIL four_mis got=%0b exp=0", misroute_o); else pass_cnt++;
    $display("four_flit: v=%0b payload=%h", v_o, payload_o);
    drain();
    total_cnt++; if (v_o !== 1'b0) $display("FAIL four_consumed got=%0b exp=0", v_o); else pass_cnt++;
  endtask

  task automatic test_header_only();
    logic [127:0] pkt;
    pkt = mk_pkt(4'd2, 4'd3, 2'd0, P_HDR);
    ready_i = 1'b1;
    send_range(pkt, 0, 0, 0);
    total_cnt++; if (v_o !== 1'b1) $display("FAIL hdr_v got=%0b exp=1", v_o); else pass_cnt++;
    total_cnt++; if (payload_o !== 118'h2ABCDE) $display("FAIL hdr_payload got=%h exp=%h", payload_o, 118'h2ABCDE); else pass_cnt++;
    $display("header_only: v=%0b payload=%h", v_o, payload_o);
    drain();
  endtask

  task automatic test_backpressure();
    logic [127:0] pa;
    logic [127:0] pb;
    pa = mk_pkt(4'd2, 4'd3, 2'd0, 118'h1111);
    pb = mk_pkt(4'd2, 4'd3, 2'd0, 118'h2222);
    ready_i = 1'b0;
    send_range(pa, 0, 0, 0);
    flit_i = pb[31:0];
    flit_v_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total_cnt++; if (flit_ready_o !== 1'b0) $display("FAIL bp_rdy%0d got=%0b exp=0", c, flit_ready_o); else pass_cnt++;
      total_cnt++; if (payload_o !== 118'h1111 || v_o !== 1'b1)
        $display("FAIL bp_hold%0d got v=%0b payload=%h exp v=1 payload=%h", c, v_o, payload_o, 118'h1111);
      else pass_cnt++;
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    #1;
    total_cnt++; if (flit_ready_o !== 1'b1) $display("FAIL bp_release_rdy got=%0b exp=1", flit_ready_o); else pass_cnt++;
    @(posedge clk_i); #1;
    flit_v_i = 1'b0;
    total_cnt++; if (v_o !== 1'b1 || payload_o !== 118'h2222)
      $display("FAIL bp_refill got v=%0b payload=%h exp v=1 payload=%h", v_o, payload_o, 118'h2222);
    else pass_cnt++;
    $display("backpressure: refill v=%0b payload=%h", v_o, payload_o);
    drain();
    total_cnt++; if (v_o !== 1'b0) $display("FAIL bp_drain got=%0b exp=0", v_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [117:0] exp_pl [3];
    logic [127:0] pkt;
    exp_pl[0] = 118'h3333; exp_pl[1] = 118'h4444; exp_pl[2] = 118'h5555;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pkt = mk_pkt(4'd2, 4'd3, 2'd0, exp_pl[i]);
      flit_i = pkt[31:0];
      flit_v_i = 1'b1;
      @(posedge clk_i); #1;
      total_cnt++; if (v_o !== 1'b1 || payload_o !== exp_pl[i])
        $display("FAIL b2b_%0d got v=%0b payload=%h exp v=1 payload=%h", i, v_o, payload_o, exp_pl[i]);
      else pass_cnt++;
      $display("back_to_back %0d: payload=%h", i, payload_o);
    end
    drain();
    total_cnt++; if (v_o !== 1'b0) $display("FAIL b2b_drain got=%0b exp=0", v_o); else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [127:0] pkt;
    pkt = mk_pkt(4'd2, 4'd3, 2'd3, P_BIG);
    ready_i = 1'b1;
    send_range(pkt, 0, 2, 2);
    repeat (2) begin
      total_cnt++; if (v_o !== 1'b0) $display("FAIL gap_v_early got=%0b exp=0", v_o); else pass_cnt++;
      @(posedge clk_i); #1;
    end
    send_range(pkt, 3, 3, 0);
    total_cnt++; if (v_o !== 1'b1 || payload_o !== P_BIG)
      $display("FAIL gap_payload got v=%0b payload=%h exp v=1 payload=%h", v_o, payload_o, P_BIG);
    else pass_cnt++;
    $display("gaps: v=%0b payload=%h", v_o, payload_o);
    drain();
  endtask

  task automatic test_misroute();
    logic [127:0] bad;
    logic [127:0] good;
    bad  = mk_pkt(4'd1, 4'd3, 2'd1, P_MIS);
    good = mk_pkt(4'd2, 4'd3, 2'd0, P_HDR);
    ready_i = 1'b1;
    total_cnt++; if (misroute_o !== 1'b0) $display("FAIL mis_before got=%0b exp=0", misroute_o); else pass_cnt++;
    send_range(bad, 0, 0, 0);
    total_cnt++; if (misroute_o !== 1'b1) $display("FAIL mis_rise got=%0b exp=1", misroute_o); else pass_cnt++;
    send_range(bad, 1, 1, 0);
    total_cnt++; if (v_o !== 1'b1 || payload_o !== P_MIS)
      $display("FAIL mis_payload got v=%0b payload=%h exp v=1 payload=%h", v_o, payload_o, P_MIS);
    else pass_cnt++;
    $display("misroute: mis=%0b payload=%h", misroute_o, payload_o);
    drain();
    send_range(good, 0, 0, 0);
    total_cnt++; if (misroute_o !== 1'b1) $display("FAIL mis_sticky got=%0b exp=1", misroute_o); else pass_cnt++;
    total_cnt++; if (len_err_o !== 1'b0) $display("FAIL lenerr got=%0b exp=0", len_err_o); else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid_packet();
    logic [127:0] pkt;
    pkt = mk_pkt(4'd2, 4'd3, 2'd3, P_BIG);
    ready_i = 1'b1;
    send_range(pkt, 0, 1, 0);
    reset_n_i = 1'b0;
    #1;
    total_cnt++; if (v_o !== 1'b0 || flit_ready_o !== 1'b0)
      $display("FAIL rst_mid got v=%0b rdy=%0b exp v=0 rdy=0", v_o, flit_ready_o);
    else pass_cnt++;
    total_cnt++; if (misroute_o !== 1'b0) $display("FAIL rst_mid_mis got=%0b exp=0", misroute_o); else pass_cnt++;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      total_cnt++; if (v_o !== 1'b0) $display("FAIL rst_no_pulse got=%0b exp=0", v_o); else pass_cnt++;
    end
    send_range(pkt, 0, 3, 0);
    total_cnt++; if (v_o !== 1'b1 || payload_o !== P_BIG)
      $display("FAIL rst_reassemble got v=%0b payload=%h exp v=1 payload=%h", v_o, payload_o, P_BIG);
    else pass_cnt++;
    $display("reset_mid_packet: v=%0b payload=%h", v_o, payload_o);
    drain();
  endtask

  initial begin
    test_reset();
    test_four_flit();
    test_header_only();
    test_backpressure();
    test_back_to_back();
    test_gaps();
    test_misroute();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bp_me_wormhole_flit_assembler.md
Name: bp_me_wormhole_flit_assembler

Overview:
- Receive side of the LCE data-command wormhole path: accepts header-on-LSB flits from one output port of the wormhole router and reassembles them into a full packet.
- Strips the x/y/len header and presents the LCE data-command payload on a valid/ready interface.
- It is the decoder counterpart of the packet encoder and input adapter used on the injection side.
- Holds one complete packet; checks the destination against the local coordinates and flags misroutes.

Parameters:
- max_num_flit_p, 4, maximum flits per packet including the header flit.
- x_cord_width_p, 4, x coordinate field width.
- y_cord_width_p, 4, y coordinate field width.
- payload_width_p, 118, LCE data-command payload width.
- len_width_lp (local), clog2(max_num_flit_p) = 2, length field width.
- packet_width_lp (local), x+y+len+payload = 128.
- flit_width_lp (local), ceil(packet_width_lp/max_num_flit_p) = 32.

Ports:
- clk_i, in, 1, clock.
- reset_n_i, in, 1, reset; asynchronous, active-low.
- my_x_i, in, x_cord_width_p, local x coordinate.
- my_y_i, in, y_cord_width_p, local y coordinate.
- flit_i, in, flit_width_lp, flit from the router.
- flit_v_i, in, 1, flit valid.
- flit_ready_o, out, 1, flit accept (ready/valid handshake).
- payload_o, out, payload_width_p, packet bits [payload_offset +: payload_width_p], where payload_offset = x+y+len = 10.
- v_o, out, 1, payload valid.
- ready_i, in, 1, consumer ready.
- misroute_o, out, 1, sticky: a header arrived whose x/y differs from my_x_i/my_y_i.
- len_err_o, out, 1, sticky: a header arrived with len > max_num_flit_p-1.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE, flit count=0, packet buffer=0.
  - v_o=0, flit_ready_o=0 while reset_n_i=0.
  - misroute_o=0, len_err_o=0.
- Field layout in packet bits, LSB first: x [3:0], y [7:4], len [9:8], payload [127:10].
- Flit k occupies packet bits [k*flit_width_lp +: flit_width_lp]. Header flit is k=0.
- len = number of body flits following the header (0..max_num_flit_p-1).
- Flit handshake: a flit transfers when flit_v_i & flit_ready_o.
- IDLE (buffer empty):
  - flit_ready_o=1.
  - On header transfer: clear the buffer, write flit 0, latch len, set count=1.
  - If len==0, go to FULL; otherwise go to COLLECT.
  - Evaluate the misroute and length checks on the header transfer.
- COLLECT:
  - flit_ready_o=1.
  - Each transfer writes flit[count] and increments count.
  - When count==len transfers, go to FULL on that cycle.
  - Flits beyond len are never written, so unused upper bits read 0.
- FULL:
  - v_o=1, payload_o stable until consumed.
  - flit_ready_o = ready_i (same-cycle drain and refill allowed).
  - On v_o & ready_i with no header transfer: go to IDLE.
  - If a header transfers the same cycle: treat it as an IDLE header (clear, write flit 0, go to COLLECT, or stay FULL if len==0).
  - Throughput: 1 packet/cycle for single-flit packets.
- Latency: v_o asserts the cycle after the last flit transfers (registered output). There is no combinational path from flit_i to payload_o.
- Misroute:
  - Set misroute_o on header transfer if x!=my_x_i or y!=my_y_i.
  - The packet is still assembled and delivered.
  - Sticky until reset.
- Length error:
  - Set len_err_o if len > max_num_flit_p-1; sticky.
  - Length is clamped to max_num_flit_p-1 so the counter never exceeds the buffer.
  - With power-of-2 max_num_flit_p this cannot occur; the check covers non-power-of-2 configurations.
- Backpressure:
  - flit_v_i deasserting mid-packet leaves the state and count unchanged (bubbles tolerated).
  - ready_i low in FULL stalls the router side indefinitely; no data is lost.
- Reset mid-packet: the partial packet is discarded, the state returns to IDLE, and no v_o pulse is produced.

Test Plan:
- 4-flit packet, header x=2,y=3,len=3, my=(2,3), payload=118'h…A5, ready_i=1.
  -> v_o on the cycle after flit 3; payload_o exact; misroute_o=0.
- Header-only packet, len=0, payload bits [31:10]=22'h2ABCDE.
  -> v_o next cycle; payload_o[21:0]=22'h2ABCDE, upper bits 0.
- ready_i=0 for 5 cycles in FULL.
  -> flit_ready_o=0 and payload_o stable; then ready_i=1 with a new header the same cycle: old packet consumed and new header accepted, with no gap.
- flit_v_i gaps of 2 cycles between body flits.
  -> packet identical to the gapless case; v_o one cycle after the final flit.
- Header x=1,y=3 with my=(2,3).
  -> misroute_o rises the cycle after the header and stays 1 across the next good packet; payload still delivered.
- reset_n_i pulsed low after 2 of 4 flits.
  -> v_o stays 0; the next full packet assembles correctly from flit 0.
